// File: rtl/crono_pkg.sv
// crono_pkg
// Shared definitions for the chronometer countdown controller.
//   - state encoding (IDLE/RUN/PAUSE/ALARM) as localparams and an enum built on them
//   - BCD limit constants for hours, tens and units digits
//   - preset_valid(): checks that an HH:MM:SS BCD preset is a legal time of day
package crono_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        ALARM = ST_ALARM
    } state_t;

    localparam logic [7:0] HOUR_MAX  = 8'h23;
    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

    // With the units digit limited to 9, the plain binary compare against
    // 8'h23 also bounds the tens digit, because BCD preserves ordering.
    function automatic logic preset_valid(input logic [7:0] h,
                                          input logic [7:0] m,
                                          input logic [7:0] s);
        return (h[3:0] <= UNITS_MAX) && (h <= HOUR_MAX) &&
               (m[7:4] <= TENS_MAX)  && (m[3:0] <= UNITS_MAX) &&
               (s[7:4] <= TENS_MAX)  && (s[3:0] <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/crono_bcd_dec.sv
// crono_bcd_dec
// Combinational one-second decrement of a BCD HH:MM:SS time.
// Ports:
//   time_in  [23:0]  {h_tens,h_units,m_tens,m_units,s_tens,s_units}
//   time_out [23:0]  time_in minus one second, BCD borrow between digits
//   zero             time_out is 00:00:00
module crono_bcd_dec
    import crono_pkg::*;
(
    input  logic [23:0] time_in,
    output logic [23:0] time_out,
    output logic        zero
);

    logic       borrow;
    logic [3:0] digit;

    // Digit limits from least to most significant. The hours-tens limit only
    // matters when decrementing 00:00:00, which the controller never does.
    function automatic logic [3:0] digit_max(input int idx);
        if (idx == 5)
            return HOUR_MAX[7:4];
        else if (idx[0])
            return TENS_MAX;
        else
            return UNITS_MAX;
    endfunction

    // Ripple a borrow upward: a zero digit wraps to its maximum and passes
    // the borrow on, any other digit absorbs it.
    always_comb begin
        borrow   = 1'b1;
        digit    = 4'd0;
        time_out = time_in;
        for (int i = 0; i < 6; i++) begin
            digit = time_in[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    time_out[4*i +: 4] = digit_max(i);
                end else begin
                    time_out[4*i +: 4] = digit - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
    end

    assign zero = (time_out == 24'h0);

endmodule

// File: rtl/crono_countdown_ctrl.sv
// crono_countdown_ctrl
// Run-time controller for the chronometer countdown: loads the BCD preset,
// decrements once per tick, supports pause/resume and cancel, and holds a
// timed alarm when the count reaches zero.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   edit_en                  setup block is editing; forces IDLE
//   start, stop              level buttons, rising edge acts
//   preset_h/m/s [7:0]       BCD preset from the setup block
//   cnt_h/m/s    [7:0]       running BCD count
//   state_o      [1:0]       IDLE=0, RUN=1, PAUSE=2, ALARM=3
//   alarm                    high while in ALARM
//   load_err                 one-cycle pulse on a rejected load
module crono_countdown_ctrl
    import crono_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_en,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] preset_h,
    input  logic [7:0] preset_m,
    input  logic [7:0] preset_s,
    output logic [7:0] cnt_h,
    output logic [7:0] cnt_m,
    output logic [7:0] cnt_s,
    output logic [1:0] state_o,
    output logic       alarm,
    output logic       load_err
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int ACNT_W = $clog2(ALARM_SECS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);

    state_t              state, state_n;
    logic [23:0]         cnt, cnt_n, dec_val, preset_all;
    logic                dec_zero;
    logic [DIV_W-1:0]    div, div_n;
    logic [ACNT_W-1:0]   acnt, acnt_n;
    logic                load_err_n;
    logic                start_q, stop_q, start_edge, stop_edge, tick;

    assign preset_all = {preset_h, preset_m, preset_s};
    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;
    assign tick       = (div == DIV_LAST);

    crono_bcd_dec u_dec (
        .time_in  (cnt),
        .time_out (dec_val),
        .zero     (dec_zero)
    );

    // Edge registers track the button level even during reset so a button
    // held through reset cannot produce an edge afterwards.
    always_ff @(posedge clk) begin
        start_q <= start;
        stop_q  <= stop;
        if (reset) begin
            state    <= IDLE;
            cnt      <= 24'h0;
            div      <= '0;
            acnt     <= '0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div      <= div_n;
            acnt     <= acnt_n;
            alarm    <= (state_n == ALARM);
            load_err <= load_err_n;
        end
    end

    // Priority: edit_en > stop edge > start edge > tick.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div;
        acnt_n     = acnt;
        load_err_n = 1'b0;
        if (edit_en) begin
            state_n = IDLE;
            cnt_n   = 24'h0;
            div_n   = '0;
            acnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    div_n  = '0;
                    acnt_n = '0;
                    // An all-zero preset is legal but pointless, so it is
                    // dropped without flagging an error.
                    if (start_edge && !stop_edge) begin
                        if (!preset_valid(preset_h, preset_m, preset_s)) begin
                            load_err_n = 1'b1;
                        end else if (preset_all != 24'h0) begin
                            cnt_n   = preset_all;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    // A pause on the tick cycle keeps the divider at its last
                    // value so the discarded tick fires right after resume.
                    if (stop_edge) begin
                        state_n = IDLE;
                        cnt_n   = 24'h0;
                        div_n   = '0;
                    end else if (start_edge) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        div_n = '0;
                        if (dec_zero) begin
                            state_n = ALARM;
                            cnt_n   = 24'h0;
                            acnt_n  = '0;
                        end else begin
                            cnt_n = dec_val;
                        end
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop_edge) begin
                        state_n = IDLE;
                        cnt_n   = 24'h0;
                        div_n   = '0;
                    end else if (start_edge) begin
                        state_n = RUN;
                    end
                end
                ALARM: begin
                    if (stop_edge || start_edge) begin
                        state_n = IDLE;
                        div_n   = '0;
                        acnt_n  = '0;
                    end else if (tick) begin
                        div_n = '0;
                        if (acnt == ACNT_LAST) begin
                            state_n = IDLE;
                            acnt_n  = '0;
                        end else begin
                            acnt_n = acnt + 1'b1;
                        end
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 24'h0;
                    div_n   = '0;
                    acnt_n  = '0;
                end
            endcase
        end
    end

    assign cnt_h   = cnt[23:16];
    assign cnt_m   = cnt[15:8];
    assign cnt_s   = cnt[7:0];
    assign state_o = state;

endmodule

// File: tb/tb_crono_countdown_ctrl.sv
// tb_crono_countdown_ctrl
// Directed testbench for crono_countdown_ctrl with TICK_DIV=4, ALARM_SECS=2.
// A seconds-based reference model is compared against the DUT every cycle,
// and hand-computed literals pin key points of each scenario.
module tb_crono_countdown_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int ALARM_SECS = 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       edit_en  = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [7:0] preset_h = 8'h0;
    logic [7:0] preset_m = 8'h0;
    logic [7:0] preset_s = 8'h0;
    logic [7:0] cnt_h, cnt_m, cnt_s;
    logic [1:0] state_o;
    logic       alarm, load_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    crono_countdown_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .edit_en  (edit_en),
        .start    (start),
        .stop     (stop),
        .preset_h (preset_h),
        .preset_m (preset_m),
        .preset_s (preset_s),
        .cnt_h    (cnt_h),
        .cnt_m    (cnt_m),
        .cnt_s    (cnt_s),
        .state_o  (state_o),
        .alarm    (alarm),
        .load_err (load_err)
    );

    // Reference model: the count is kept as plain seconds, the divider as
    // cycles elapsed within the current second.
    int m_mode   = 0;
    int m_secs   = 0;
    int m_phase  = 0;
    int m_ticks  = 0;
    bit m_err    = 1'b0;
    bit m_sq     = 1'b0;
    bit m_tq     = 1'b0;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit model_valid(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s);
        if (h[3:0] > 9 || h[7:4] > 9 || bcd2int(h) > 23) return 1'b0;
        if (m[3:0] > 9 || m[7:4] > 5) return 1'b0;
        if (s[3:0] > 9 || s[7:4] > 5) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] secs_to_bcd(input int v);
        int h, m, s;
        h = v / 3600;
        m = (v / 60) % 60;
        s = v % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge clk) begin : model
        bit se, te;
        se   = start && !m_sq;
        te   = stop && !m_tq;
        m_sq = start;
        m_tq = stop;
        if (reset) begin
            m_mode = 0; m_secs = 0; m_phase = 0; m_ticks = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (edit_en) begin
                m_mode = 0; m_secs = 0; m_phase = 0; m_ticks = 0;
            end else begin
                case (m_mode)
                    0: if (se && !te) begin
                        if (!model_valid(preset_h, preset_m, preset_s)) begin
                            m_err = 1'b1;
                        end else begin
                            m_secs = bcd2int(preset_h) * 3600 + bcd2int(preset_m) * 60
                                     + bcd2int(preset_s);
                            if (m_secs != 0) begin
                                m_mode  = 1;
                                m_phase = 0;
                            end
                        end
                    end
                    1: begin
                        if (te) begin
                            m_mode = 0; m_secs = 0; m_phase = 0;
                        end else if (se) begin
                            m_mode = 2;
                        end else begin
                            m_phase++;
                            if (m_phase == TICK_DIV) begin
                                m_phase = 0;
                                m_secs--;
                                if (m_secs == 0) begin
                                    m_mode  = 3;
                                    m_ticks = 0;
                                end
                            end
                        end
                    end
                    2: begin
                        if (te) begin
                            m_mode = 0; m_secs = 0; m_phase = 0;
                        end else if (se) begin
                            m_mode = 1;
                        end
                    end
                    default: begin
                        if (te || se) begin
                            m_mode = 0; m_phase = 0; m_ticks = 0;
                        end else begin
                            m_phase++;
                            if (m_phase == TICK_DIV) begin
                                m_phase = 0;
                                m_ticks++;
                                if (m_ticks == ALARM_SECS) begin
                                    m_mode  = 0;
                                    m_ticks = 0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_state", 24'(state_o), 24'(m_mode));
            checkOutput("model_cnt", {cnt_h, cnt_m, cnt_s}, secs_to_bcd(m_secs));
            checkOutput("model_alarm", 24'(alarm), 24'(m_mode == 3));
            checkOutput("model_load_err", 24'(load_err), 24'(m_err));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the requested buttons for one cycle, then release them.
    task automatic applyStimulus(input bit s, input bit p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic setPreset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        preset_h = h;
        preset_m = m;
        preset_s = s;
    endtask

    function automatic logic [23:0] cnt_all();
        return {cnt_h, cnt_m, cnt_s};
    endfunction

    logic [7:0] bad_h [3] = '{8'h24, 8'h00, 8'h00};
    logic [7:0] bad_m [3] = '{8'h00, 8'h60, 8'h0A};

    initial begin
        waitCycles(2);
        checkOutput("reset_state", 24'(state_o), 24'd0);
        checkOutput("reset_cnt", cnt_all(), 24'h0);
        checkOutput("reset_alarm", 24'(alarm), 24'd0);
        check_en = 1'b1;
        reset    = 1'b0;
        waitCycles(1);

        $display("[TB] countdown 00:00:03 into alarm");
        setPreset(8'h00, 8'h00, 8'h03);
        applyStimulus(1'b1, 1'b0);
        checkOutput("run_state", 24'(state_o), 24'd1);
        checkOutput("run_load", cnt_all(), 24'h000003);
        waitCycles(4);
        checkOutput("dec_02", cnt_all(), 24'h000002);
        waitCycles(4);
        checkOutput("dec_01", cnt_all(), 24'h000001);
        waitCycles(4);
        checkOutput("dec_00", cnt_all(), 24'h000000);
        checkOutput("alarm_state", 24'(state_o), 24'd3);
        checkOutput("alarm_on", 24'(alarm), 24'd1);
        waitCycles(7);
        checkOutput("alarm_last", 24'(alarm), 24'd1);
        waitCycles(1);
        checkOutput("alarm_end_state", 24'(state_o), 24'd0);
        checkOutput("alarm_end", 24'(alarm), 24'd0);

        $display("[TB] hour borrow");
        setPreset(8'h10, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        checkOutput("borrow_10h", cnt_all(), 24'h095959);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_state", 24'(state_o), 24'd0);
        checkOutput("stop_cnt", cnt_all(), 24'h0);
        setPreset(8'h01, 8'h00, 8'h00);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        checkOutput("borrow_1h", cnt_all(), 24'h005959);
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);

        $display("[TB] pause and resume");
        setPreset(8'h00, 8'h01, 8'h00);
        applyStimulus(1'b1, 1'b0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pause_state", 24'(state_o), 24'd2);
        waitCycles(20);
        checkOutput("pause_frozen", cnt_all(), 24'h000100);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resume_state", 24'(state_o), 24'd1);
        waitCycles(1);
        checkOutput("resume_hold", cnt_all(), 24'h000100);
        waitCycles(1);
        checkOutput("resume_dec", cnt_all(), 24'h000059);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pause_on_tick", cnt_all(), 24'h000059);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0);
        waitCycles(1);
        checkOutput("tick_after_resume", cnt_all(), 24'h000058);
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);

        $display("[TB] invalid and zero presets");
        for (int i = 0; i < 3; i++) begin
            setPreset(bad_h[i], bad_m[i], 8'h00);
            applyStimulus(1'b1, 1'b0);
            checkOutput("err_pulse", 24'(load_err), 24'd1);
            checkOutput("err_state", 24'(state_o), 24'd0);
            checkOutput("err_cnt", cnt_all(), 24'h0);
            waitCycles(1);
            checkOutput("err_clear", 24'(load_err), 24'd0);
        end
        setPreset(8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0);
        checkOutput("zero_no_err", 24'(load_err), 24'd0);
        checkOutput("zero_idle", 24'(state_o), 24'd0);
        waitCycles(1);

        $display("[TB] control conflicts");
        setPreset(8'h00, 8'h00, 8'h10);
        applyStimulus(1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("conf_pause", 24'(state_o), 24'd2);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("conf_both_state", 24'(state_o), 24'd0);
        checkOutput("conf_both_cnt", cnt_all(), 24'h0);
        waitCycles(1);
        setPreset(8'h00, 8'h02, 8'h00);
        applyStimulus(1'b1, 1'b0);
        waitCycles(2);
        edit_en = 1'b1;
        waitCycles(1);
        checkOutput("edit_state", 24'(state_o), 24'd0);
        checkOutput("edit_cnt", cnt_all(), 24'h0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("edit_ignore", 24'(state_o), 24'd0);
        waitCycles(1);
        edit_en = 1'b0;
        waitCycles(1);

        $display("[TB] reset during alarm with start held");
        setPreset(8'h00, 8'h00, 8'h01);
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        checkOutput("pre_reset_alarm", 24'(state_o), 24'd3);
        waitCycles(2);
        start = 1'b1;
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rst_state", 24'(state_o), 24'd0);
        checkOutput("rst_alarm", 24'(alarm), 24'd0);
        checkOutput("rst_cnt", cnt_all(), 24'h0);
        reset = 1'b0;
        waitCycles(3);
        checkOutput("no_spurious_start", 24'(state_o), 24'd0);
        start = 1'b0;
        waitCycles(2);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
